// File: rtl/pc_unit_pkg.sv
// Shared constants for the program-counter unit: zero word and FSM state encodings.
package pc_unit_pkg;

   localparam int STATE_W = 2;
   localparam logic [63:0] WORD_ZERO = 64'd0;

   typedef enum logic [STATE_W-1:0] {
      PC_BOOT = 2'd0,
      PC_RUN  = 2'd1,
      PC_HALT = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_unit_next_mux.sv
// Combinational next-PC priority select: jr > jmp > br_taken > sequential.
module pc_next_mux #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] pc_plus_i,
   input  logic             br_taken_i,
   input  logic [WIDTH-1:0] br_target_i,
   input  logic             jmp_i,
   input  logic [WIDTH-1:0] jmp_target_i,
   input  logic             jr_i,
   input  logic [WIDTH-1:0] jr_target_i,
   output logic [WIDTH-1:0] next_pc_o,
   output logic             redirect_o
);

   always_comb begin
      next_pc_o  = pc_plus_i;
      redirect_o = 1'b1;
      if (jr_i) begin
         next_pc_o = jr_target_i;
      end else if (jmp_i) begin
         next_pc_o = jmp_target_i;
      end else if (br_taken_i) begin
         next_pc_o = br_target_i;
      end else begin
         redirect_o = 1'b0;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter with BOOT/RUN/HALT control, redirect flush and stall.
// Optional target alignment check enabled by PC_ALIGN_CHECK_EN.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               INC          = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             halt_req,
   input  logic             resume,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             jmp,
   input  logic [WIDTH-1:0] jmp_target,
   input  logic             jr,
   input  logic [WIDTH-1:0] jr_target,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus,
   output logic             pc_valid,
   output logic             flush,
   output logic [1:0]       state,
   output logic             misalign
);

   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

   pc_state_e        state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             valid_q, valid_d;
   logic             flush_q, flush_d;
   logic             misalign_q, misalign_d;
   logic [WIDTH-1:0] mux_pc;
   logic             redirect;
   logic             target_bad;

   assign pc_plus = pc_q + WIDTH'(INC);

   pc_next_mux #(.WIDTH(WIDTH)) u_next_mux (
      .pc_plus_i    (pc_plus),
      .br_taken_i   (br_taken),
      .br_target_i  (br_target),
      .jmp_i        (jmp),
      .jmp_target_i (jmp_target),
      .jr_i         (jr),
      .jr_target_i  (jr_target),
      .next_pc_o    (mux_pc),
      .redirect_o   (redirect)
   );

`ifdef PC_ALIGN_CHECK_EN
   // A mask of zero (INC=1) makes every target acceptable.
   assign target_bad = redirect && ((mux_pc & ALIGN_MASK) != WORD_ZERO[WIDTH-1:0]);
`else
   assign target_bad = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      flush_d    = 1'b0;
      misalign_d = 1'b0;
      case (state_q)
         PC_BOOT: state_d = PC_RUN;
         PC_RUN: begin
            if (target_bad) begin
               misalign_d = 1'b1;
               state_d    = PC_HALT;
            end else if (redirect) begin
               // Redirects win over both stall and halt entry.
               pc_d    = mux_pc;
               flush_d = 1'b1;
               if (halt_req) state_d = PC_HALT;
            end else if (halt_req) begin
               state_d = PC_HALT;
            end else if (!stall) begin
               pc_d = pc_plus;
            end
         end
         PC_HALT: begin
            if (resume && !halt_req) state_d = PC_RUN;
         end
         default: begin
            state_d = PC_BOOT;
            pc_d    = RESET_VECTOR;
         end
      endcase
      valid_d = (state_d == PC_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= PC_BOOT;
         pc_q       <= RESET_VECTOR;
         valid_q    <= 1'b0;
         flush_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         flush_q    <= flush_d;
         misalign_q <= misalign_d;
      end
   end

   assign pc       = pc_q;
   assign pc_valid = valid_q;
   assign flush    = flush_q;
   assign state    = state_q;
   assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with RESET_VECTOR=0x100, INC=4.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, halt_req, resume, br_taken, jmp, jr;
   logic [31:0] br_target, jmp_target, jr_target;
   logic [31:0] pc, pc_plus;
   logic        pc_valid, flush, misalign;
   logic [1:0]  state;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h100), .INC(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .resume(resume),
      .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
      .jr(jr), .jr_target(jr_target), .pc(pc), .pc_plus(pc_plus), .pc_valid(pc_valid),
      .flush(flush), .state(state), .misalign(misalign)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall = 0; halt_req = 0; resume = 0;
      br_taken = 0; jmp = 0; jr = 0;
      br_target = 0; jmp_target = 0; jr_target = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      #2;
      total++; if (pc !== 32'h100) $display("FAIL reset_pc: got %h want %h", pc, 32'h100); else pass_cnt++;
      total++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else pass_cnt++;
      total++; if (pc_valid !== 1'b0 || flush !== 1'b0 || misalign !== 1'b0)
         $display("FAIL reset_flags: got v=%b f=%b m=%b want 000", pc_valid, flush, misalign); else pass_cnt++;
      step();
      rst = 0;
      // BOOT must ignore a redirect request
      jmp = 1; jmp_target = 32'h700;
      step();
      jmp = 0;
      total++; if (state !== 2'd1 || pc_valid !== 1'b1) $display("FAIL boot_to_run: got st=%0d v=%b want 1 1", state, pc_valid); else pass_cnt++;
      total++; if (pc !== 32'h100 || flush !== 1'b0) $display("FAIL boot_hold: got pc=%h f=%b want 100 0", pc, flush); else pass_cnt++;
      step();
      total++; if (pc !== 32'h104) $display("FAIL seq1: got %h want 104", pc); else pass_cnt++;
      step();
      total++; if (pc !== 32'h108) $display("FAIL seq2: got %h want 108", pc); else pass_cnt++;
      total++; if (pc_plus !== 32'h10c) $display("FAIL pc_plus: got %h want 10c", pc_plus); else pass_cnt++;
   endtask

   task automatic test_stall();
      jmp = 1; jmp_target = 32'h200;
      step();
      jmp = 0;
      total++; if (pc !== 32'h200 || flush !== 1'b1) $display("FAIL jmp_200: got pc=%h f=%b want 200 1", pc, flush); else pass_cnt++;
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (pc !== 32'h200 || flush !== 1'b0) $display("FAIL stall_hold%0d: got pc=%h f=%b want 200 0", i, pc, flush); else pass_cnt++;
      end
      stall = 0;
      step();
      total++; if (pc !== 32'h204) $display("FAIL stall_release: got %h want 204", pc); else pass_cnt++;
   endtask

   task automatic test_priority();
      jr = 1; jr_target = 32'h400;
      jmp = 1; jmp_target = 32'h500;
      br_taken = 1; br_target = 32'h600;
      stall = 1;
      step();
      clear_inputs();
      stall = 1;
      total++; if (pc !== 32'h400 || flush !== 1'b1) $display("FAIL prio_jr: got pc=%h f=%b want 400 1", pc, flush); else pass_cnt++;
      step();
      total++; if (pc !== 32'h400 || flush !== 1'b0) $display("FAIL flush_once: got pc=%h f=%b want 400 0", pc, flush); else pass_cnt++;
      stall = 0;
      jmp = 1; jmp_target = 32'h500; br_taken = 1; br_target = 32'h600;
      step();
      clear_inputs();
      total++; if (pc !== 32'h500) $display("FAIL prio_jmp: got %h want 500", pc); else pass_cnt++;
      br_taken = 1; br_target = 32'h600;
      step();
      clear_inputs();
      total++; if (pc !== 32'h600) $display("FAIL prio_br: got %h want 600", pc); else pass_cnt++;
   endtask

   task automatic test_halt();
      halt_req = 1; br_taken = 1; br_target = 32'h800;
      step();
      clear_inputs();
      total++; if (pc !== 32'h800 || state !== 2'd2) $display("FAIL halt_br: got pc=%h st=%0d want 800 2", pc, state); else pass_cnt++;
      total++; if (pc_valid !== 1'b0 || flush !== 1'b1) $display("FAIL halt_flags: got v=%b f=%b want 0 1", pc_valid, flush); else pass_cnt++;
      jmp = 1; jmp_target = 32'h900;
      step();
      clear_inputs();
      total++; if (pc !== 32'h800 || flush !== 1'b0 || state !== 2'd2)
         $display("FAIL halt_ignore: got pc=%h f=%b st=%0d want 800 0 2", pc, flush, state); else pass_cnt++;
      halt_req = 1; resume = 1;
      step();
      clear_inputs();
      total++; if (state !== 2'd2) $display("FAIL halt_resume_conflict: got %0d want 2", state); else pass_cnt++;
      resume = 1;
      step();
      clear_inputs();
      total++; if (state !== 2'd1 || pc_valid !== 1'b1 || pc !== 32'h800)
         $display("FAIL resume: got st=%0d v=%b pc=%h want 1 1 800", state, pc_valid, pc); else pass_cnt++;
      step();
      total++; if (pc !== 32'h804) $display("FAIL post_resume: got %h want 804", pc); else pass_cnt++;
      halt_req = 1;
      step();
      clear_inputs();
      total++; if (pc !== 32'h804 || state !== 2'd2) $display("FAIL halt_plain: got pc=%h st=%0d want 804 2", pc, state); else pass_cnt++;
      resume = 1;
      step();
      clear_inputs();
   endtask

   task automatic test_wrap_and_async_reset();
      jmp = 1; jmp_target = 32'hFFFF_FFFC;
      step();
      clear_inputs();
      total++; if (pc_plus !== 32'h0) $display("FAIL wrap_plus: got %h want 0", pc_plus); else pass_cnt++;
      step();
      total++; if (pc !== 32'h0) $display("FAIL wrap_pc: got %h want 0", pc); else pass_cnt++;
      jr = 1; jr_target = 32'h1230;
      #2;
      rst = 1;
      #1;
      total++; if (pc !== 32'h100 || state !== 2'd0 || pc_valid !== 1'b0)
         $display("FAIL async_rst: got pc=%h st=%0d v=%b want 100 0 0", pc, state, pc_valid); else pass_cnt++;
      step();
      clear_inputs();
      rst = 0;
      step();
      total++; if (state !== 2'd1 || pc !== 32'h100) $display("FAIL rst_reboot: got st=%0d pc=%h want 1 100", state, pc); else pass_cnt++;
   endtask

   task automatic test_align();
      jmp = 1; jmp_target = 32'h302;
      step();
      clear_inputs();
`ifdef PC_ALIGN_CHECK_EN
      total++; if (pc !== 32'h100 || misalign !== 1'b1 || state !== 2'd2 || flush !== 1'b0)
         $display("FAIL align_reject: got pc=%h m=%b st=%0d f=%b want 100 1 2 0", pc, misalign, state, flush); else pass_cnt++;
`else
      total++; if (pc !== 32'h302 || misalign !== 1'b0 || flush !== 1'b1)
         $display("FAIL align_take: got pc=%h m=%b f=%b want 302 0 1", pc, misalign, flush); else pass_cnt++;
`endif
      step();
      total++; if (misalign !== 1'b0) $display("FAIL misalign_pulse: got %b want 0", misalign); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_stall();
      test_priority();
      test_halt();
      test_wrap_and_async_reset();
      test_align();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
